// File: rtl/multi_chan_pingpong_buf.sv
// multi_chan_pingpong_buf: multi-channel ping-pong capture buffer between the
// ADC front end and the FSMC host bus. While one bank fills with post-trigger
// samples, the host reads the other bank.
// Optional feature macro: MCB_DECIM_EN enables sample decimation through
// control bits [7:0]. When it is undefined, decimation is fixed at 1:1.
module multi_chan_pingpong_buf #(
  parameter int          DATA_WIDTH  = 12,
  parameter int          DEPTH       = 1024,
  parameter int          CHANNELS    = 2,
  parameter logic [15:0] STATUS_ADDR = 16'h4000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sample_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] sample_data,
  input  logic                           stable,
  input  logic                           trig_in,
  input  logic                           en,
  input  logic                           state,
  input  logic [15:0]                    addr,
  input  logic [15:0]                    din,
  output logic [15:0]                    dout,
  output logic                           ready
);

  localparam int          AW         = $clog2(DEPTH);
  localparam int          PW         = AW + 1;
  localparam int          BANK_WORDS = CHANNELS * DEPTH;
  localparam int          MW         = $clog2(2 * BANK_WORDS);
  localparam logic [15:0] CTRL_ADDR  = STATUS_ADDR + 16'd1;
  localparam logic [15:0] DATA_LIMIT = 16'(BANK_WORDS);

  typedef enum logic [1:0] {IDLE, ARMED, FILL, FULL} fsm_e;

  fsm_e                  fsm_q, fsm_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [7:0]            dcnt_q, dcnt_d;
  logic                  wb_q, ready_q, reading_q;
  logic [7:0]            ovf_q;
  logic                  trig_fall_q, auto_q, trig_q;
  logic [15:0]           dout_q, rdata;
  logic [7:0]            decim_m1;
  logic                  mem_we, swap, ovf_inc;
  logic                  stat_wr, ctrl_wr, host_rd, reading_eff, trig_edge;
  logic [MW-1:0]         wr_base, rd_idx;
  logic [DATA_WIDTH-1:0] mem_q [2*BANK_WORDS];
  logic                  din_unused;

  assign host_rd   = en & state;
  assign stat_wr   = en & ~state & (addr == STATUS_ADDR);
  assign ctrl_wr   = en & ~state & (addr == CTRL_ADDR);
  // A status write in the same cycle as bank completion decides overflow.
  assign reading_eff = stat_wr ? din[0] : reading_q;
  assign trig_edge = trig_fall_q ? (trig_q & ~trig_in) : (~trig_q & trig_in);
  assign wr_base   = (wb_q ? MW'(BANK_WORDS) : '0) + MW'(ptr_q[AW-1:0]);
  assign rd_idx    = (wb_q ? '0 : MW'(BANK_WORDS)) + MW'(addr);
  assign dout      = dout_q;
  assign ready     = ready_q;

`ifdef MCB_DECIM_EN
  logic [7:0] decim_q;
  assign decim_m1   = decim_q;
  assign din_unused = ^din[15:10];

  // Decimation ratio register, written through the control address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       decim_q <= '0;
    else if (ctrl_wr) decim_q <= din[7:0];
  end
`else
  assign decim_m1   = '0;
  assign din_unused = ^{din[15:10], din[7:1]};
`endif

  // Writer FSM: next state, fill pointer, decimation count and bank swap.
  always_comb begin
    fsm_d   = fsm_q;
    ptr_d   = ptr_q;
    dcnt_d  = dcnt_q;
    mem_we  = 1'b0;
    swap    = 1'b0;
    ovf_inc = 1'b0;
    case (fsm_q)
      IDLE: begin
        ptr_d  = '0;
        dcnt_d = '0;
        if (stable) fsm_d = ARMED;
      end
      ARMED: begin
        if (!stable)                  fsm_d = IDLE;
        else if (trig_edge || auto_q) fsm_d = FILL;
      end
      FILL: begin
        if (!stable) begin
          fsm_d = IDLE;
        end else if (sample_valid) begin
          dcnt_d = (dcnt_q == decim_m1) ? 8'd0 : dcnt_q + 8'd1;
          if (dcnt_q == 8'd0) begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            if (ptr_q == PW'(DEPTH - 1)) begin
              fsm_d   = FULL;
              ovf_inc = reading_eff;
            end
          end
        end
      end
      FULL: begin
        if (!reading_q) begin
          swap   = 1'b1;
          ptr_d  = '0;
          dcnt_d = '0;
          fsm_d  = stable ? ARMED : IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Writer FSM state, pointers and trigger history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      ptr_q  <= '0;
      dcnt_q <= '0;
      trig_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      ptr_q  <= ptr_d;
      dcnt_q <= dcnt_d;
      trig_q <= trig_in;
    end
  end

  // Sample storage: all channels are written together at the fill pointer.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int c = 0; c < CHANNELS; c++) begin
        mem_q[wr_base + MW'(c * DEPTH)] <= sample_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Host read mux over status, control and the read bank.
  always_comb begin
    rdata = '0;
    if (addr == STATUS_ADDR)     rdata = {ovf_q, 5'b0, wb_q, reading_q, ready_q};
    else if (addr == CTRL_ADDR)  rdata = {6'b0, auto_q, trig_fall_q, decim_m1};
    else if (addr < DATA_LIMIT)  rdata = 16'(mem_q[rd_idx]);
  end

  // Host-visible registers; a swap's ready set overrides a release clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q      <= '0;
      ready_q     <= 1'b0;
      reading_q   <= 1'b0;
      wb_q        <= 1'b0;
      ovf_q       <= '0;
      trig_fall_q <= 1'b0;
      auto_q      <= 1'b0;
    end else begin
      if (host_rd) dout_q <= rdata;
      if (ctrl_wr) begin
        trig_fall_q <= din[8];
        auto_q      <= din[9];
      end
      if (stat_wr) reading_q <= din[0];
      if (swap) begin
        wb_q    <= ~wb_q;
        ready_q <= 1'b1;
      end else if (stat_wr && !din[0]) begin
        ready_q <= 1'b0;
      end
      if (stat_wr && !din[0])              ovf_q <= '0;
      else if (ovf_inc && ovf_q != 8'hFF)  ovf_q <= ovf_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_multi_chan_pingpong_buf.sv
// Directed testbench for multi_chan_pingpong_buf: captures, overflow/release,
// trigger polarity, decimation and stable-loss abort, with table-driven
// host reads checked against hand-computed values.
module tb_multi_chan_pingpong_buf;

  localparam int DEPTH = 1024;
`ifdef MCB_DECIM_EN
  localparam int          DM    = 4;
  localparam logic [15:0] CTRL3 = 16'h0003;
`else
  localparam int          DM    = 1;
  localparam logic [15:0] CTRL3 = 16'h0000;
`endif
  localparam logic [15:0] STAT = 16'h4000;
  localparam logic [15:0] CTRL = 16'h4001;

  logic        clk, rst_n, sample_valid, stable, trig_in, en, state, ready;
  logic [23:0] sample_data;
  logic [15:0] addr, din, dout;

  typedef struct {
    int          phase;
    logic [15:0] addr;
    logic [15:0] expv;
    string       name;
  } readVec_t;

  readVec_t vecs[$];
  int       assertCount = 0;
  int       failCount   = 0;

  multi_chan_pingpong_buf dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .sample_data(sample_data), .stable(stable), .trig_in(trig_in),
    .en(en), .state(state), .addr(addr), .din(din), .dout(dout),
    .ready(ready)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net against a hung run.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
    assertCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic v, input int d0, input int d1);
    sample_valid = v;
    sample_data  = {12'(d1), 12'(d0)};
    tick();
  endtask

  task automatic busWrite(input logic [15:0] a, input logic [15:0] d);
    en = 1'b1; state = 1'b0; addr = a; din = d;
    tick();
    en = 1'b0;
  endtask

  task automatic busRead(input logic [15:0] a, output logic [15:0] d);
    en = 1'b1; state = 1'b1; addr = a;
    tick();
    en = 1'b0; state = 1'b0;
    d = dout;
  endtask

  task automatic runTable(input int ph);
    logic [15:0] d;
    foreach (vecs[i]) begin
      if (vecs[i].phase == ph) begin
        busRead(vecs[i].addr, d);
        checkOutput(vecs[i].name, d, vecs[i].expv);
      end
    end
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, base + i, base + i + 100);
    sample_valid = 1'b0;
  endtask

  task automatic pulseTrig;
    trig_in = 1'b0;
    tick();
    trig_in = 1'b1;
    tick();
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    checkOutput(name, {15'b0, ready}, 16'h0001);
  endtask

  function automatic void addVec(input int ph, input logic [15:0] a, input logic [15:0] e, input string nm);
    readVec_t v;
    v.phase = ph; v.addr = a; v.expv = e; v.name = nm;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [15:0] d;

    addVec(0, STAT,     16'h0000, "reset_status");
    addVec(0, CTRL,     16'h0000, "reset_control");
    addVec(1, 16'd5,    16'd5,    "cap1_ch0_addr5");
    addVec(1, 16'd1029, 16'd105,  "cap1_ch1_addr1029");
    addVec(1, STAT,     16'h0005, "cap1_status");
    addVec(1, 16'd0,    16'd0,    "cap1_ch0_first");
    addVec(1, 16'd1023, 16'd1023, "cap1_ch0_last");
    addVec(1, 16'd2047, 16'd1123, "cap1_ch1_last");
    addVec(1, 16'd2048, 16'h0000, "unmapped_2048");
    addVec(1, 16'h3000, 16'h0000, "unmapped_3000");
    addVec(2, STAT,     16'h0107, "overflow_status");
    addVec(2, 16'd5,    16'd5,    "locked_bank_addr5");
    addVec(3, STAT,     16'h0001, "release_status");
    addVec(3, 16'd5,    16'd2005, "cap2_ch0_addr5");
    addVec(3, 16'd1029, 16'd2105, "cap2_ch1_addr1029");
    addVec(4, CTRL,     16'h0100, "trigfall_control");
    addVec(4, 16'd0,    16'd500,  "fall_ch0_first");
    addVec(4, 16'd1024, 16'd600,  "fall_ch1_first");
    addVec(4, STAT,     16'h0005, "fall_status");
    addVec(5, CTRL,     CTRL3,    "decim_control");
    addVec(5, 16'd1,    16'(DM),  "decim_addr1");
    addVec(5, 16'd1023, 16'(DM * 1023), "decim_addr1023");
    addVec(5, 16'd1025, 16'(DM + 100),  "decim_ch1_addr1025");
    addVec(5, STAT,     16'h0001, "decim_status");
    addVec(6, STAT,     16'h0000, "abort_status");
    addVec(7, STAT,     16'h0005, "refill_status");
    addVec(7, 16'd0,    16'd700,  "refill_ch0_first");
    addVec(7, 16'd1023, 16'd1723, "refill_ch0_last");
    addVec(7, 16'd1024, 16'd800,  "refill_ch1_first");

    rst_n = 1'b0; sample_valid = 1'b0; sample_data = '0; stable = 1'b0;
    trig_in = 1'b0; en = 1'b0; state = 1'b0; addr = '0; din = '0;
    repeat (2) tick();
    checkOutput("reset_dout", dout, 16'h0000);
    checkOutput("reset_ready", {15'b0, ready}, 16'h0000);
    rst_n = 1'b1;
    tick();
    runTable(0);

    $display("[TB] first capture");
    stable = 1'b1;
    tick();
    pulseTrig();
    fill(DEPTH, 0);
    waitReady("cap1_ready");
    runTable(1);

    $display("[TB] host locks bank, second capture overflows");
    busWrite(STAT, 16'h0001);
    pulseTrig();
    fill(DEPTH, 2000);
    repeat (3) tick();
    runTable(2);

    $display("[TB] host releases bank, pending swap completes");
    busWrite(STAT, 16'h0000);
    checkOutput("release_clears_ready", {15'b0, ready}, 16'h0000);
    tick();
    checkOutput("swap_ready", {15'b0, ready}, 16'h0001);
    runTable(3);

    $display("[TB] falling-edge trigger");
    trig_in = 1'b0;
    tick();
    busWrite(CTRL, 16'h0100);
    trig_in = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 3000 + i, 3000 + i);
    trig_in = 1'b0;
    applyStimulus(1'b1, 4000, 4000);
    fill(DEPTH, 500);
    repeat (2) tick();
    runTable(4);

    $display("[TB] decimation");
    busWrite(CTRL, 16'h0003);
    pulseTrig();
    fill(4 * DEPTH, 0);
    repeat (2) tick();
    runTable(5);

    $display("[TB] stable loss aborts a partial bank");
    busWrite(CTRL, 16'h0000);
    busWrite(STAT, 16'h0000);
    pulseTrig();
    fill(500, 1000);
    stable = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1, 1);
    sample_valid = 1'b0;
    tick();
    checkOutput("abort_ready", {15'b0, ready}, 16'h0000);
    runTable(6);
    stable = 1'b1;
    tick();
    pulseTrig();
    fill(DEPTH, 700);
    waitReady("refill_ready");
    runTable(7);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/multi_chan_pingpong_buf.md
# multi_chan_pingpong_buf

Parametrised multi-channel ping-pong capture buffer between the synchronised ADC front end and the FSMC host bus. Stores DEPTH post-trigger samples per channel into one bank while the host reads the other. Adds configurable trigger edge, free-run mode, sample decimation and host-side overflow reporting. Sits in the system clock domain; all inputs arrive already synchronised.

## Interface
- DATA_WIDTH, 12, bits per ADC sample (≤16; zero-extended on readout)
- DEPTH, 1024, samples per channel per bank (power of two)
- CHANNELS, 2, parallel ADC channels (1–4; CHANNELS*DEPTH ≤ STATUS_ADDR)
- STATUS_ADDR, 16'h4000, status register address; control register at STATUS_ADDR+1
---
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sample_valid  in  1  one-cycle strobe, sample_data valid
- sample_data  in  CHANNELS*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- stable  in  1  front end settled; capture permitted only while high
- trig_in  in  1  synchronised comparator square wave
- en  in  1  bus access strobe, one cycle per access
- state  in  1  1 = read, 0 = write
- addr  in  16  bus address
- din  in  16  bus write data
- dout  out  16  bus read data
- ready  out  1  a completed bank is available (mirror of status bit 0)

## Operation
- Data address map: addr = c*DEPTH + i reads sample i of channel c from the read bank (= !write_bank). Addresses ≥ CHANNELS*DEPTH other than the two registers read 0.
- Status (read): [15:8] overflow_cnt, [7:3] 0, [2] write_bank, [1] reading, [0] ready.
- Status (write): din[0]=1 → reading=1 (host locks read bank); din[0]=0 → reading=0, ready=0, overflow_cnt=0.
- Control (R/W): [7:0] decim_m1, [8] trig_fall (0 rising, 1 falling), [9] auto (free-run, ignore trig_in), [15:10] read 0. Reset value 0.
- Writer FSM:
  - IDLE: ptr=0, decim counter=0. stable=1 → ARMED.
  - ARMED: selected edge of trig_in (registered trig_in vs current), or auto=1 → FILL.
  - FILL: on each sample_valid, decim counter counts 0..decim_m1; at 0 write all channels at ptr into write_bank, ptr++. ptr reaching DEPTH → FULL.
  - FULL: reading=0 → toggle write_bank, ready=1, ptr=0, → ARMED (IDLE if stable=0). reading=1 → stay; samples discarded.
- stable falling in ARMED/FILL → IDLE; partial bank discarded, write_bank unchanged.
- overflow_cnt: 8-bit, saturates at 255; increments once on each FULL entry with reading=1.
- Bus writes to data addresses are ignored.

## Timing
- Reset: dout=0, ready=0, write_bank=0, reading=0, overflow_cnt=0, control=0, FSM IDLE.
- Bus read: dout registered, valid the cycle after en&state; held until next read.
- Bus write: register updates at the en&!state edge; visible to the FSM the following cycle.
- Trigger edge to first stored sample: edge detected in cycle N, FSM in FILL at N+1; first sample_valid at or after N+1 stored.
- Swap: one cycle after FULL entry when reading=0; ready rises same edge as write_bank toggles.
- Simultaneous host write of 1 and FULL entry: write wins, no swap, overflow_cnt increments.
- Simultaneous host write of 0 and swap: ready ends 1 (swap set takes priority over release clear).
- sample_valid in the FULL→ARMED cycle is discarded.

## Configuration
- MCB_DECIM_EN defined: decimation as above.
- Undefined: decim_m1 forced 0 (reads 0, writes ignored); every sample_valid in FILL is stored.

## Test plan
- Reset, stable=1, rising trig, 1024 samples data=i (both channels, ch1=i+100) → ready=1, write_bank=1; read addr 5 → 5, addr 1029 → 105, status → 16'h0005.
- Host writes status=1, second full capture completes → no swap, overflow_cnt=1, status reads 16'h0107; write 0 → swap next cycle, status 16'h0001.
- Control=16'h0003 (decim 4), data=i for 4096 valids → addr k reads 4k.
- Control bit 8 set, trig rising only → no capture; falling edge → capture starts next cycle.
- stable drops after 500 samples → FSM IDLE, ready stays 0, write_bank=0; re-trigger fills full bank.
- Without MCB_DECIM_EN: write control=16'h0003, read back 16'h0000; every sample stored.
